// File: rtl/lift_pkg.sv
// lift_pkg: shared FSM encodings and call-scan helpers for the lift scheduler
package lift_pkg;
  localparam int ST_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_DOOR = 2'd2;
  function automatic logic any_above(input logic [15:0] p, input logic [3:0] f);
    any_above = |(p >> (f + 5'd1));
  endfunction
  function automatic logic any_below(input logic [15:0] p, input logic [3:0] f);
    any_below = |(p & ((16'd1 << f) - 16'd1));
  endfunction
endpackage

// File: rtl/lift_tick_timer.sv
// lift_tick_timer: counts slow reference strobes, flags the limit-th one
module lift_tick_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       slowref,
  input  logic [7:0] limit,
  output logic       done
);
  logic [7:0] cnt;
  assign done = slowref && cnt == limit - 8'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr || done) cnt <= '0;
    else if (slowref) cnt <= cnt + 8'd1;
endmodule

// File: rtl/lift_scheduler.sv
// lift_scheduler: single-car SCAN scheduler with call latching, motion and door timing
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3,
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slowref,
  input  logic [NUM_FLOORS-1:0] call_sw,
  input  logic                  obstruct,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  logic [ST_W-1:0] state, state_n;
  logic [NUM_FLOORS-1:0] call_q, rise, here, nhere, latch, clear;
  logic [FLOOR_W-1:0] next_floor;
  logic cf_edge, done, step, door_done, ahead_dir, ahead_next, new_dir, timer_clr;
  assign rise       = call_sw & ~call_q;
  assign here       = NUM_FLOORS'(1) << cur_floor;
  assign next_floor = dir_up ? cur_floor + 1'b1 : cur_floor - 1'b1;
  assign nhere      = NUM_FLOORS'(1) << next_floor;
  assign cf_edge    = |(rise & here);
  assign step       = state == ST_MOVE && done;
  assign door_done  = state == ST_DOOR && done && !obstruct && !cf_edge;
  assign ahead_dir  = dir_up ? any_above(16'(pending), 4'(cur_floor)) : any_below(16'(pending), 4'(cur_floor));
  assign ahead_next = dir_up ? any_above(16'(pending), 4'(next_floor)) : any_below(16'(pending), 4'(next_floor));
  assign new_dir    = cur_floor == '0 ? 1'b1 : cur_floor == TOP ? 1'b0 : ahead_dir ? dir_up : ~dir_up;
  assign moving     = state == ST_MOVE;
  assign door_open  = state == ST_DOOR;
  // A call at the car's own floor is served by the door, never latched, unless the car is travelling
  assign latch      = rise & ~(state != ST_MOVE ? here : '0);
  assign clear      = state == ST_DOOR ? here : '0;
  always_comb
    state_n = state == ST_IDLE ? ((cf_edge || |(pending & here)) ? ST_DOOR : |pending ? ST_MOVE : ST_IDLE)
            : state == ST_MOVE ? (!step ? ST_MOVE : |(pending & nhere) ? ST_DOOR : ahead_next ? ST_MOVE : ST_IDLE)
            : state == ST_DOOR ? (door_done ? ST_IDLE : ST_DOOR)
            : ST_IDLE;
  assign timer_clr = state_n != state || step || state == ST_IDLE || (state == ST_DOOR && (obstruct || cf_edge));
  lift_tick_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .slowref (slowref),
    .limit   (state == ST_MOVE ? 8'(MOVE_TICKS) : 8'(DOOR_TICKS)),
    .done    (done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= ST_IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      call_q    <= '0;
    end else begin
      state     <= state_n;
      cur_floor <= step ? next_floor : cur_floor;
      dir_up    <= (state == ST_IDLE && state_n == ST_MOVE) ? new_dir : dir_up;
      pending   <= (pending | latch) & ~clear;
      call_q    <= call_sw;
    end
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios with a status-change scoreboard
module tb_lift_scheduler;
  logic clk = 0, reset = 1, slowref = 0, obstruct = 0;
  logic [7:0] call_sw = '0;
  logic [2:0] cur_floor;
  logic dir_up, moving, door_open;
  logic [7:0] pending;
  logic [5:0] exp_q[$];
  int checks = 0, fails = 0;

  lift_scheduler #(.NUM_FLOORS(8), .FLOOR_W(3), .MOVE_TICKS(4), .DOOR_TICKS(8)) dut (
    .clk(clk), .reset(reset), .slowref(slowref), .call_sw(call_sw), .obstruct(obstruct),
    .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving), .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(negedge clk);
    slowref = 1;
    @(negedge clk);
    slowref = 0;
  end

  function automatic logic [5:0] st(input int f, input bit d, input bit m, input bit o);
    st = {3'(f), d, m, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  // Monitor: every change of the visible car status must match the next queued expectation
  initial begin
    logic [5:0] last, cur, e;
    last = '0;
    forever begin
      @(negedge clk);
      cur = {cur_floor, dir_up, moving, door_open};
      if (reset) last = cur;
      else if (cur !== last) begin
        last = cur;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_status got %h required no change", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL status_seq got %h required %h", cur, e);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_door(input string name);
    int n = 0;
    while (!door_open && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_door_wait"}, 32'(door_open), 1);
  endtask

  task automatic strobes_to_close(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (slowref) n++;
      #1;
      if (!door_open) break;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({cur_floor, dir_up, moving, door_open, pending}), 32'({3'd0, 1'b1, 1'b0, 1'b0, 8'h00}));
    reset = 0;
    // 1: single call to floor 3
    exp_q.push_back(st(0,1,1,0));
    exp_q.push_back(st(1,1,1,0));
    exp_q.push_back(st(2,1,1,0));
    exp_q.push_back(st(3,1,0,1));
    exp_q.push_back(st(3,1,0,0));
    @(negedge clk) call_sw[3] = 1;
    @(negedge clk);
    chk("s1_pending_latch", 32'(pending), 32'h08);
    chk("s1_not_moving_yet", 32'(moving), 0);
    call_sw[3] = 0;
    drain("s1");
    chk("s1_pending_clear", 32'(pending), 0);
    // 2: calls at 5 and 1 from floor 3 heading up
    exp_q.push_back(st(3,1,1,0));
    exp_q.push_back(st(4,1,1,0));
    exp_q.push_back(st(5,1,0,1));
    exp_q.push_back(st(5,1,0,0));
    exp_q.push_back(st(5,0,1,0));
    exp_q.push_back(st(4,0,1,0));
    exp_q.push_back(st(3,0,1,0));
    exp_q.push_back(st(2,0,1,0));
    exp_q.push_back(st(1,0,0,1));
    exp_q.push_back(st(1,0,0,0));
    @(negedge clk) call_sw = 8'h22;
    @(negedge clk);
    chk("s2_pending_latch", 32'(pending), 32'h22);
    call_sw = '0;
    drain("s2");
    chk("s2_end", 32'({cur_floor, dir_up, pending}), 32'({3'd1, 1'b0, 8'h00}));
    // 3: obstruction and same-floor call at floor 2
    exp_q.push_back(st(1,1,1,0));
    exp_q.push_back(st(2,1,0,1));
    exp_q.push_back(st(2,1,0,0));
    exp_q.push_back(st(2,1,0,1));
    exp_q.push_back(st(2,1,0,0));
    @(negedge clk) call_sw[2] = 1;
    @(negedge clk) call_sw[2] = 0;
    wait_door("s3a");
    obstruct = 1;
    repeat (80) @(negedge clk);
    chk("s3_obstruct_hold", 32'(door_open), 1);
    obstruct = 0;
    strobes_to_close(n);
    chk("s3_obstruct_release_strobes", 32'(n), 8);
    repeat (3) @(negedge clk);
    call_sw[2] = 1;
    @(negedge clk) call_sw[2] = 0;
    wait_door("s3b");
    repeat (12) @(negedge clk);
    call_sw[2] = 1;
    @(posedge clk);
    strobes_to_close(n);
    chk("s3_call_restart_strobes", 32'(n), 8);
    @(negedge clk) call_sw[2] = 0;
    chk("s3_pending_zero", 32'(pending), 0);
    drain("s3");
    // 5: reset between floors 4 and 5
    exp_q.push_back(st(2,1,1,0));
    exp_q.push_back(st(3,1,1,0));
    exp_q.push_back(st(4,1,1,0));
    @(negedge clk) call_sw[6] = 1;
    @(negedge clk) call_sw[6] = 0;
    n = 0;
    while (cur_floor != 3'd4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("s5_reach_4", 32'(cur_floor), 4);
    repeat (8) @(negedge clk);
    chk("s5_pending_before", 32'(pending), 32'h40);
    #1 reset = 1;
    exp_q.delete();
    #1 chk("s5_async_reset", 32'({cur_floor, dir_up, moving, door_open, pending}), 32'({3'd0, 1'b1, 1'b0, 1'b0, 8'h00}));
    repeat (2) @(negedge clk);
    reset = 0;
    // 4: same-floor call while idle at floor 0
    exp_q.push_back(st(0,1,0,1));
    exp_q.push_back(st(0,1,0,0));
    @(negedge clk) call_sw[0] = 1;
    @(negedge clk);
    chk("s4_direct_door", 32'({moving, door_open, pending}), 32'({1'b0, 1'b1, 8'h00}));
    call_sw[0] = 0;
    drain("s4");
    chk("s4_pending_zero", 32'(pending), 0);
    // 6: held call to the top floor
    exp_q.push_back(st(0,1,1,0));
    for (int f = 1; f < 7; f++) exp_q.push_back(st(f,1,1,0));
    exp_q.push_back(st(7,1,0,1));
    exp_q.push_back(st(7,1,0,0));
    @(negedge clk) call_sw[7] = 1;
    drain("s6");
    chk("s6_pending_once", 32'(pending), 0);
    repeat (40) @(negedge clk);
    chk("s6_top_stop", 32'({cur_floor, moving, door_open, pending}), 32'({3'd7, 1'b0, 1'b0, 8'h00}));
    call_sw[7] = 0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
